// File: rtl/psram_burst_writer.sv
// Streams BURST_LEN-word bursts from the pixel FIFO into pSRAM write bursts with frame-wrapping addresses.
// Define PSRAM_WR_STAT_EN to build the underflow flag and the per-frame burst counter.
module psram_burst_writer #(
    parameter int unsigned BURST_LEN   = 64,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 2073600
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    input  logic [15:0]       fifo_rdata,
    input  logic              fifo_prog_empty,
    input  logic              fifo_rempty,
    output logic              fifo_ren,
    output logic              psram_req,
    output logic [ADDR_W-1:0] psram_addr,
    output logic [8:0]        psram_len,
    input  logic              psram_ack,
    output logic [15:0]       psram_wdata,
    output logic              psram_wvalid,
    output logic              psram_wlast,
    output logic              frame_done,
    output logic              underflow,
    output logic [15:0]       burst_count
);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(BASE_ADDR + FRAME_WORDS);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(BURST_LEN);
    localparam logic [7:0]        BEAT_LAST = 8'(BURST_LEN - 1);
    localparam logic [8:0]        LEN       = 9'(BURST_LEN);

    // state | meaning
    // IDLE  | waiting for a full burst in the FIFO
    // REQ   | burst request held until the controller grants it
    // DATA  | BURST_LEN back-to-back FIFO reads
    // DONE  | last word drains; address advances, wraps or restarts
    typedef enum logic [1:0] {IDLE, REQ, DATA, DONE} state_t;

    state_t            state, state_nxt;
    logic [7:0]        beat;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_inc;
    logic              wrap;
    logic              restart_now;
    logic              done_restart;
    logic              fs_pend;
    logic              wvalid_q;
    logic              wlast_q;
    logic              frame_done_q;
    logic [8:0]        len_q;

    assign addr_inc     = addr + STEP;
    assign wrap         = (addr_inc == END_ADDR);
    // Once granted, the burst address is frozen; later restarts wait for DONE.
    assign restart_now  = frame_start && ((state == IDLE) || (state == REQ && !psram_ack));
    assign done_restart = wrap || fs_pend || frame_start;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_ren  = 1'b0;
        psram_req = 1'b0;
        unique case (state)
            IDLE: if (!fifo_prog_empty && !fifo_rempty) state_nxt = REQ;
            REQ: begin
                psram_req = 1'b1;
                if (psram_ack) state_nxt = DATA;
            end
            DATA: begin
                fifo_ren = 1'b1;
                if (beat == 8'd0) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat         <= 8'd0;
            addr         <= BASE;
            fs_pend      <= 1'b0;
            wvalid_q     <= 1'b0;
            wlast_q      <= 1'b0;
            frame_done_q <= 1'b0;
            len_q        <= 9'd0;
        end else begin
            len_q        <= LEN;
            wvalid_q     <= fifo_ren;
            wlast_q      <= fifo_ren && (beat == 8'd0);
            frame_done_q <= 1'b0;

            if (state == REQ)       beat <= BEAT_LAST;
            else if (state == DATA) beat <= beat - 8'd1;

            if (restart_now) begin
                addr <= BASE;
            end else if (state == DONE) begin
                addr         <= done_restart ? BASE : addr_inc;
                frame_done_q <= wrap;
            end

            if (state == DONE)                     fs_pend <= 1'b0;
            else if (frame_start && !restart_now)  fs_pend <= 1'b1;
        end
    end

    assign psram_addr   = addr;
    assign psram_len    = len_q;
    assign psram_wvalid = wvalid_q;
    assign psram_wlast  = wlast_q;
    assign frame_done   = frame_done_q;
    // fifo_rdata already carries the word read on the previous cycle, so it lines up with wvalid.
    assign psram_wdata  = wvalid_q ? fifo_rdata : 16'd0;

`ifdef PSRAM_WR_STAT_EN
    logic        uf_q;
    logic [15:0] bc_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            uf_q <= 1'b0;
            bc_q <= 16'd0;
        end else begin
            if (fifo_ren && fifo_rempty) uf_q <= 1'b1;
            if (restart_now) begin
                bc_q <= 16'd0;
            end else if (state == DONE) begin
                if (done_restart)         bc_q <= 16'd0;
                else if (bc_q != 16'hFFFF) bc_q <= bc_q + 16'd1;
            end
        end
    end

    assign underflow   = uf_q;
    assign burst_count = bc_q;
`else
    assign underflow   = 1'b0;
    assign burst_count = 16'd0;
`endif

endmodule

// File: doc/psram_burst_writer.md
# psram_burst_writer

Single-clock burst write sequencer on the read side of the 16-bit pixel FIFO that feeds the pSRAM frame buffer. Waits until the FIFO holds at least one burst of data, requests a write burst from the pSRAM controller, and streams exactly `BURST_LEN` 16-bit words from the FIFO to the controller. Generates linear word addresses that wrap at frame end, and marks each completed frame.

## Interface
- `BURST_LEN`, 64: words per burst; power of two, 4..256; must equal the FIFO `prog_empty` threshold.
- `ADDR_W`, 24: pSRAM word-address width.
- `BASE_ADDR`, 0: first word address of the frame buffer.
- `FRAME_WORDS`, 2073600: words per frame (1920x1080 at 16 bit); integer multiple of `BURST_LEN`.

Ports:
- `clk` input 1: FIFO read clock; all logic is on this clock.
- `reset` input 1: synchronous, active-high.
- `frame_start` input 1: one-cycle pulse that restarts addressing at `BASE_ADDR`.
- `fifo_rdata` input 16: FIFO read data, valid the cycle after `fifo_ren`.
- `fifo_prog_empty` input 1: high when the FIFO holds fewer than `BURST_LEN` words.
- `fifo_rempty` input 1: FIFO empty.
- `fifo_ren` output 1: FIFO read enable.
- `psram_req` output 1: burst write request.
- `psram_addr` output ADDR_W: burst start word address; stable while `psram_req` is high.
- `psram_len` output 9: burst length, constant `BURST_LEN`.
- `psram_ack` input 1: one-cycle grant from the controller.
- `psram_wdata` output 16: write data.
- `psram_wvalid` output 1: write data valid.
- `psram_wlast` output 1: marks the last word of a burst.
- `frame_done` output 1: one-cycle pulse after the last burst of a frame.
- `underflow` output 1: sticky flag for a read issued while the FIFO was empty (stat build only).
- `burst_count` output 16: completed bursts in the current frame (stat build only).

## Operation
- The block is a state machine with four states: IDLE, REQ, DATA, DONE.
- **IDLE:** If `fifo_prog_empty`=0 and `fifo_rempty`=0, go to REQ on the next cycle.
- **REQ:** `psram_req`=1 and `psram_addr`=current address. Hold both until `psram_ack` is sampled high, then go to DATA. No timeout applies.
- **DATA:** `fifo_ren`=1 for exactly `BURST_LEN` consecutive cycles, tracked by a beat counter. After the last beat, go to DONE.
  - `fifo_ren` is not gated by `fifo_rempty`; the controller requires contiguous data.
  - A read issued while `fifo_rempty`=1 sets `underflow`. The word is still forwarded.
- **DONE:** One cycle, used to drain the final data word.
  - Address advances by `BURST_LEN`.
  - If the new address equals `BASE_ADDR+FRAME_WORDS`, the address wraps to `BASE_ADDR`, `frame_done` pulses, and `burst_count` clears.
  - Otherwise, `burst_count` increments.
  - Then return to IDLE.
- **Data path:**
  - `psram_wvalid` is `fifo_ren` delayed by one cycle.
  - `psram_wdata` is `fifo_rdata` registered on the same cycle.
  - `psram_wlast` accompanies the word read on the last DATA beat.
- **`frame_start` in IDLE or REQ:** The address resets to `BASE_ADDR` immediately. In REQ, `psram_addr` updates only if `psram_ack` has not yet been seen; a granted address never changes.
- **`frame_start` in DATA or DONE:** The pulse is latched. The running burst completes untouched, and the reset is applied in place of the DONE address update. `frame_done` does not pulse for this case.
- **`frame_start` coinciding with a natural wrap:** One reset takes effect and `frame_done` pulses once.
- **Address arithmetic:** Unsigned, `ADDR_W` bits. Wrap is compared against `BASE_ADDR+FRAME_WORDS` evaluated at elaboration.
- **Reset:** Reset at any time, including mid-burst, forces:
  - IDLE;
  - address=`BASE_ADDR`;
  - all outputs to 0, including `psram_len`, which returns to `BURST_LEN` on the first cycle after reset;
  - the latched `frame_start` cleared;
  - statistics cleared.

## Timing
- **Reset values:** `fifo_ren`, `psram_req`, `psram_wvalid`, `psram_wlast`, `frame_done`, `underflow` = 0; `psram_addr`=`BASE_ADDR`; `burst_count`=0; `psram_wdata`=0.
- **IDLE→REQ:** `psram_req` rises 1 cycle after the FIFO condition is sampled true.
- **Ack to data:** An ack at cycle T gives `fifo_ren` high on T+1..T+`BURST_LEN`, and `psram_wvalid` high on T+2..T+`BURST_LEN`+1. `psram_wlast` is on T+`BURST_LEN`+1.
- **Burst end:** DONE is at T+`BURST_LEN`+1. `frame_done` and the address update are registered, visible at T+`BURST_LEN`+2. IDLE is at T+`BURST_LEN`+2.
- **Throughput:** Minimum burst-to-burst spacing is `BURST_LEN`+3 cycles plus controller ack latency.
- **Ack outside REQ:** Ignored.

## Configuration
- `PSRAM_WR_STAT_EN` defined: `underflow` sticky flag and the 16-bit `burst_count` are implemented; `burst_count` saturates at 0xFFFF.
- Without it: `underflow` and `burst_count` are tied to 0, and no statistics registers are built. All other behaviour is identical.

## Test plan
- **Single burst:** After reset, set `fifo_prog_empty`=0 and give an ack 3 cycles after req → exactly 64 `fifo_ren` cycles; 64 `psram_wvalid` words matching FIFO data; `psram_wlast` on word 64; `psram_addr`=0, then next addr=64.
- **Ack stall:** Hold `psram_ack` low 100 cycles → `psram_req`/`psram_addr` stable for all 100 cycles; no `fifo_ren` before the ack.
- **Frame wrap:** Set `FRAME_WORDS`=256 and run 4 bursts → addresses 0, 64, 128, 192; one `frame_done` pulse after the 4th; 5th burst address=0.
- **Mid-burst `frame_start`:** Pulse at beat 10 of the burst at address 128 → burst finishes all 64 words; next address=0; no `frame_done`.
- **Underflow (stat build):** Assert `fifo_rempty` on beat 30 → `underflow`=1 and stays set; 64 words still emitted. In the non-stat build, `underflow` stays 0.
- **Reset mid-burst:** Assert `reset` at beat 20 → next cycle all outputs 0 and `psram_addr`=`BASE_ADDR`; a fresh burst requests from address 0.
